lcd_text_writer: RTL and testbench

Upstream feeder for the LCD controller: accepts a byte stream of characters from the bus or CPU side and turns it into the byte/command transactions the controller executes. Issues the HD44780 power-on init sequence after reset. Tracks the cursor on a 2-row display and translates control characters (LF, CR, FF) and end-of-line wrap into set-DDRAM-address and clear commands. A small input FIFO decouples the producer from the slow LCD transactions.

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_text_writer_if.sv | 22 ++
 rtl/lcd_char_fifo.sv | 45 ++++
 rtl/lcd_text_writer.sv | 153 +++++++++++++++
 tb/tb_lcd_text_writer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the LCD text writer.
// HD44780 command bytes, control characters, the power-on init table and the FSM enums.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DDRAM    = 8'h80;
    localparam logic [7:0] ROW1_BASE    = 8'h40;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_FF = 8'h0C;

    localparam int INIT_LEN = 4;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CTRL,
        S_WRAP,
        S_CHAR
    } main_state_e;

    typedef enum logic [1:0] {
        T_IDLE,
        T_REQ,
        T_REL
    } tr_state_e;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

    function automatic logic [7:0] ddram_row(input logic row);
        return CMD_DDRAM | (row ? ROW1_BASE : 8'h00);
    endfunction

endpackage

// File: rtl/lcd_text_writer_if.sv
// Producer-side character stream plus the 4-phase request/ack link to the LCD controller.
// The writer takes the slave modport; whoever drives characters and acks takes the master.
interface lcd_text_writer_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       busy;
    logic [7:0] lcd_data;
    logic       lcd_is_cmd;
    logic       lcd_req;
    logic       lcd_ack;

    modport slave (
        input  char_in, char_valid, lcd_ack,
        output char_ready, busy, lcd_data, lcd_is_cmd, lcd_req
    );

    modport master (
        output char_in, char_valid, lcd_ack,
        input  char_ready, busy, lcd_data, lcd_is_cmd, lcd_req
    );
endinterface

// File: rtl/lcd_char_fifo.sv
// Synchronous FIFO with a combinational head read; pushes are ignored when full, pops when empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module lcd_char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem[rd_ptr_q[AW-1:0]];

    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign wr_ptr_d = do_push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/lcd_text_writer.sv
// Turns a character stream into HD44780 command/data transactions, with power-on init and 2-row cursor tracking.
// One 4-phase transaction in flight at a time; producer is backpressured only when the input FIFO is full.
module lcd_text_writer
    import lcd_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    lcd_text_writer_if.slave   bus
);
    localparam int             CW      = $clog2(COLS + 1);
    localparam logic [CW-1:0]  COL_MAX = CW'(COLS);

    main_state_e   state_q, state_d;
    tr_state_e     tr_q, tr_d;
    logic [1:0]    idx_q, idx_d;
    logic          row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    c_q, c_d;
    logic [7:0]    data_q, data_d;
    logic          is_cmd_q, is_cmd_d;

    logic          fifo_full, fifo_empty, pop;
    logic [7:0]    head;
    logic          start, done, tr_free;
    logic [7:0]    tx_dat;
    logic          tx_cmd;

    lcd_char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.char_valid),
        .wdata_i (bus.char_in),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.char_ready = !fifo_full;
    assign bus.lcd_req    = (tr_q == T_REQ);
    assign bus.lcd_data   = data_q;
    assign bus.lcd_is_cmd = is_cmd_q;
    assign bus.busy       = (state_q != S_IDLE) || !fifo_empty || (tr_q != T_IDLE);

    // A new request may only start once the previous ack has been released.
    assign tr_free = (tr_q == T_IDLE) && !bus.lcd_ack;
    assign done    = (tr_q == T_REL) && !bus.lcd_ack;

    always_comb begin
        tr_d     = tr_q;
        data_d   = data_q;
        is_cmd_d = is_cmd_q;
        case (tr_q)
            T_IDLE: if (start) begin
                tr_d     = T_REQ;
                data_d   = tx_dat;
                is_cmd_d = tx_cmd;
            end
            T_REQ:   if (bus.lcd_ack) tr_d = T_REL;
            T_REL:   if (!bus.lcd_ack) tr_d = T_IDLE;
            default: tr_d = T_IDLE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        c_d     = c_q;
        pop     = 1'b0;
        start   = 1'b0;
        tx_dat  = 8'h00;
        tx_cmd  = 1'b0;
        case (state_q)
            S_INIT: begin
                tx_cmd = 1'b1;
                tx_dat = init_cmd(idx_q);
                start  = tr_free;
                if (done) begin
                    if (idx_q == 2'(INIT_LEN - 1)) state_d = S_IDLE;
                    else                            idx_d   = idx_q + 2'd1;
                end
            end
            S_IDLE: if (!fifo_empty) begin
                pop = 1'b1;
                c_d = head;
                if (head == CH_LF || head == CH_CR || head == CH_FF) state_d = S_CTRL;
                else if (col_q == COL_MAX)                             state_d = S_WRAP;
                else                                                   state_d = S_CHAR;
            end
            S_CTRL: begin
                tx_cmd = 1'b1;
                case (c_q)
                    CH_LF:   tx_dat = ddram_row(!row_q);
                    CH_CR:   tx_dat = ddram_row(row_q);
                    default: tx_dat = CMD_CLEAR;
                endcase
                start = tr_free;
                if (done) begin
                    if (c_q == CH_LF)      row_d = !row_q;
                    else if (c_q == CH_FF) row_d = 1'b0;
                    col_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_WRAP: begin
                tx_cmd = 1'b1;
                tx_dat = ddram_row(!row_q);
                start  = tr_free;
                if (done) begin
                    row_d   = !row_q;
                    col_d   = '0;
                    state_d = S_CHAR;
                end
            end
            S_CHAR: begin
                tx_dat = c_q;
                start  = tr_free;
                if (done) begin
                    col_d   = col_q + CW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT;
            tr_q     <= T_IDLE;
            idx_q    <= '0;
            row_q    <= 1'b0;
            col_q    <= '0;
            c_q      <= '0;
            data_q   <= '0;
            is_cmd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tr_q     <= tr_d;
            idx_q    <= idx_d;
            row_q    <= row_d;
            col_q    <= col_d;
            c_q      <= c_d;
            data_q   <= data_d;
            is_cmd_q <= is_cmd_d;
        end
    end
endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer: a 3-cycle ack model with stall control and a transaction log.
module tb_lcd_text_writer;
    localparam int COLS  = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_text_writer_if bus();

    lcd_text_writer #(.COLS(COLS), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         stall    = 1'b0;
    int         ack_cnt  = 0;
    int         viol     = 0;
    logic [8:0] txq[$];
    logic       prev_req = 1'b0;
    logic [8:0] prev_tx  = '0;

    // Log each new request, flag protocol breaches, then model the controller ack.
    always @(negedge clk) begin
        if (bus.lcd_req && !prev_req) begin
            if (bus.lcd_ack) viol++;
            txq.push_back({bus.lcd_is_cmd, bus.lcd_data});
        end
        if (bus.lcd_req && prev_req && ({bus.lcd_is_cmd, bus.lcd_data} != prev_tx)) viol++;
        prev_req = bus.lcd_req;
        prev_tx  = {bus.lcd_is_cmd, bus.lcd_data};
        if (rst) begin
            bus.lcd_ack = 1'b0;
            ack_cnt     = 0;
        end else if (bus.lcd_req && !bus.lcd_ack) begin
            if (!stall) begin
                ack_cnt++;
                if (ack_cnt >= 3) begin
                    bus.lcd_ack = 1'b1;
                    ack_cnt     = 0;
                end
            end
        end else if (!bus.lcd_req && bus.lcd_ack) begin
            bus.lcd_ack = 1'b0;
        end
    end

    task automatic push(input logic [7:0] c);
        int t = 0;
        @(negedge clk);
        while (!bus.char_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: char_ready=%b required 1", bus.char_ready);
        end
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        @(negedge clk);
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (bus.busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.char_in = 8'h00;
        bus.char_valid = 1'b0;
        bus.lcd_ack = 1'b0;
        #1;
        n_checks++; if (bus.lcd_req !== 1'b0)     begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.lcd_req); end
        n_checks++; if (bus.lcd_data !== 8'h00)   begin n_fail++; $display("FAIL rst_data: got %h want 00", bus.lcd_data); end
        n_checks++; if (bus.lcd_is_cmd !== 1'b0)  begin n_fail++; $display("FAIL rst_is_cmd: got %b want 0", bus.lcd_is_cmd); end
        n_checks++; if (bus.char_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.char_ready); end
        n_checks++; if (bus.busy !== 1'b1)        begin n_fail++; $display("FAIL rst_busy: got %b want 1", bus.busy); end
        n_checks++; if (dut.row_q !== 1'b0 || dut.col_q !== 5'd0) begin
            n_fail++; $display("FAIL rst_cursor: got row %b col %0d want 0,0", dut.row_q, dut.col_q);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_init();
        logic [7:0] exp_init[4];
        exp_init[0] = 8'h38; exp_init[1] = 8'h0C; exp_init[2] = 8'h01; exp_init[3] = 8'h06;
        wait_idle();
        n_checks++; if (txq.size() !== 4) begin n_fail++; $display("FAIL init_count: got %0d want 4", txq.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (txq.size() <= i || txq[i] !== {1'b1, exp_init[i]}) begin
                n_fail++; $display("FAIL init_cmd%0d: got %h want %h", i, (txq.size() > i) ? txq[i] : 9'h0, {1'b1, exp_init[i]});
            end
        end
        n_checks++; if (bus.lcd_ack !== 1'b0) begin n_fail++; $display("FAIL init_busy_after_ack: ack=%b want 0", bus.lcd_ack); end
    endtask

    task automatic test_single_char();
        txq.delete();
        push(8'h41);
        wait_idle();
        n_checks++;
        if (txq.size() !== 1 || txq[0] !== 9'h041) begin
            n_fail++; $display("FAIL single_char: got n=%0d first=%h want n=1 041", txq.size(), (txq.size() > 0) ? txq[0] : 9'h0);
        end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL handshake_protocol: got %0d violations want 0", viol); end
        n_checks++; if (dut.col_q !== 5'd1) begin n_fail++; $display("FAIL single_col: got %0d want 1", dut.col_q); end
    endtask

    task automatic test_wrap();
        logic [8:0] exp[$];
        // Start from home so the 17 characters land at columns 0..15 then wrap.
        push(8'h0C);
        wait_idle();
        txq.delete();
        for (int i = 0; i < 17; i++) push(8'h61 + 8'(i));
        wait_idle();
        for (int i = 0; i < 16; i++) exp.push_back({1'b0, 8'h61 + 8'(i)});
        exp.push_back(9'h1C0);
        exp.push_back(9'h071);
        n_checks++; if (txq.size() !== 18) begin n_fail++; $display("FAIL wrap_count: got %0d want 18", txq.size()); end
        for (int i = 0; i < 18; i++) begin
            n_checks++;
            if (txq.size() <= i || txq[i] !== exp[i]) begin
                n_fail++; $display("FAIL wrap_tx%0d: got %h want %h", i, (txq.size() > i) ? txq[i] : 9'h0, exp[i]);
            end
        end
        n_checks++; if (dut.row_q !== 1'b1 || dut.col_q !== 5'd1) begin
            n_fail++; $display("FAIL wrap_cursor: got row %b col %0d want 1,1", dut.row_q, dut.col_q);
        end
    endtask

    task automatic test_ctrl_chars();
        txq.delete();
        push(8'h0A);
        push(8'h5A);
        wait_idle();
        n_checks++;
        if (txq.size() !== 2 || txq[0] !== 9'h180 || txq[1] !== 9'h05A) begin
            n_fail++; $display("FAIL lf_then_z: got n=%0d %h %h want 180 05A", txq.size(), (txq.size() > 0) ? txq[0] : 9'h0, (txq.size() > 1) ? txq[1] : 9'h0);
        end
        n_checks++; if (dut.row_q !== 1'b0 || dut.col_q !== 5'd1) begin
            n_fail++; $display("FAIL lf_cursor: got row %b col %0d want 0,1", dut.row_q, dut.col_q);
        end
        txq.delete();
        push(8'h0A);
        push(8'h0D);
        wait_idle();
        n_checks++;
        if (txq.size() !== 2 || txq[0] !== 9'h1C0 || txq[1] !== 9'h1C0) begin
            n_fail++; $display("FAIL lf_cr_row1: got n=%0d %h %h want 1C0 1C0", txq.size(), (txq.size() > 0) ? txq[0] : 9'h0, (txq.size() > 1) ? txq[1] : 9'h0);
        end
        txq.delete();
        push(8'h0C);
        wait_idle();
        n_checks++;
        if (txq.size() !== 1 || txq[0] !== 9'h101) begin
            n_fail++; $display("FAIL ff_clear: got n=%0d %h want 101", txq.size(), (txq.size() > 0) ? txq[0] : 9'h0);
        end
        n_checks++; if (dut.row_q !== 1'b0 || dut.col_q !== 5'd0) begin
            n_fail++; $display("FAIL ff_cursor: got row %b col %0d want 0,0", dut.row_q, dut.col_q);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        txq.delete();
        stall = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (acc < 10 && bus.char_ready) begin
                bus.char_in = 8'h30 + 8'(acc);
                bus.char_valid = 1'b1;
                acc++;
            end else begin
                bus.char_valid = 1'b0;
            end
        end
        // One byte has been popped into the stalled transaction, so DEPTH more fill the FIFO.
        n_checks++; if (acc !== DEPTH + 1) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", acc, DEPTH + 1); end
        n_checks++; if (bus.char_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", bus.char_ready); end
        stall = 1'b0;
        for (int k = 0; k < 400 && acc < 10; k++) begin
            @(negedge clk);
            if (bus.char_ready) begin
                bus.char_in = 8'h30 + 8'(acc);
                bus.char_valid = 1'b1;
                acc++;
            end else begin
                bus.char_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.char_valid = 1'b0;
        wait_idle();
        n_checks++; if (txq.size() !== 10) begin n_fail++; $display("FAIL bp_count: got %0d want 10", txq.size()); end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (txq.size() <= i || txq[i] !== {1'b0, 8'h30 + 8'(i)}) begin
                n_fail++; $display("FAIL bp_order%0d: got %h want %h", i, (txq.size() > i) ? txq[i] : 9'h0, {1'b0, 8'h30 + 8'(i)});
            end
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        stall = 1'b1;
        push(8'h78);
        push(8'h79);
        push(8'h7A);
        while (!bus.lcd_req && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++; if (bus.lcd_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_seen: got %b want 1", bus.lcd_req); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.lcd_req !== 1'b0)    begin n_fail++; $display("FAIL mid_req_drop: got %b want 0", bus.lcd_req); end
        n_checks++; if (dut.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL mid_fifo_empty: got %b want 1", dut.fifo_empty); end
        n_checks++; if (bus.busy !== 1'b1)       begin n_fail++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
        stall = 1'b0;
        @(negedge clk);
        txq.delete();
        @(negedge clk);
        rst = 1'b0;
        wait_idle();
        n_checks++;
        if (txq.size() !== 4 || txq[0] !== 9'h138 || txq[3] !== 9'h106) begin
            n_fail++; $display("FAIL mid_reinit: got n=%0d first=%h want n=4 138..106", txq.size(), (txq.size() > 0) ? txq[0] : 9'h0);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_single_char();
        test_wrap();
        test_ctrl_chars();
        test_backpressure();
        test_reset_mid();
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL handshake_final: got %0d violations want 0", viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
